medidor_pulsos: RTL and testbench
=================================

Name: medidor_pulsos

Overview:
- Wheel-sensor front end of the velocimetro datapath.
- Synchronises and debounces the raw hall/reed pulse, then counts debounced rising edges over a fixed time window.
- At each window end, presents the integer distance numerator `numero1` (pulses × wheel circumference in mm) and the divisor `numero2` (mm per metre).
- Drives them into the int→float / divide / accumulate stage with the `validar` / `listosNumeros` strobes and the `recibido1` / `recibido2` ready feedback.

Parameters:
- VENTANA_CICLOS, 50000000, clock cycles per measurement window (1 s at 50 MHz).
- DEBOUNCE_CICLOS, 50000, consecutive stable cycles required to accept a sensor level change.
- CIRCUNF_MM, 2100, wheel circumference in mm.
- DIVISOR, 1000, value driven on `numero2` (mm→m).
- LATENCIA, 40, cycles from `validar` to `listosNumeros`; covers downstream float pipeline depth.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sensor  in  1  raw wheel sensor, asynchronous to `clock`
- recibido1  in  1  downstream ready for `numero1`
- recibido2  in  1  downstream ready for `numero2`
- numero1  out  32  pulses × CIRCUNF_MM, unsigned
- numero2  out  32  DIVISOR, unsigned
- validar  out  1  one-cycle strobe: accumulate this sample
- listosNumeros  out  1  one-cycle strobe: downstream result may be taken
- pulsos_ventana  out  16  pulse count of the last delivered window
- error_sobrecarga  out  1  sticky: a window ended before the previous one was delivered

Behaviour:
- **Reset.** Asynchronous, active-high. All outputs reset to 0, including `numero2` (it is loaded with DIVISOR at the first capture). Internal state: FSM=CONTAR, counters=0, filtered level=0.
- **Sensor conditioning.**
  - 2-FF synchroniser, then a debounce counter.
  - Filtered level takes the synchronised value after DEBOUNCE_CICLOS consecutive equal cycles that differ from the current filtered level. Any bounce restarts the count.
  - A rising edge of the filtered level is one pulse.
  - Latency from a clean `sensor` edge to pulse: 2 + DEBOUNCE_CICLOS cycles.
- **Window counter.** Free-running 0..VENTANA_CICLOS-1; wraps to 0. Wrap cycle = "fin_ventana".
- **Pulse counter.** 16-bit, saturates at 65535.
  - A pulse on the fin_ventana cycle belongs to the ending window.
  - Counter clears on fin_ventana; counting continues in every FSM state.
- **FSM states: CONTAR, ENTREGAR, ESPERAR.**
  - **CONTAR, on fin_ventana:** capture in one cycle
    - `pulsos_ventana` = count
    - `numero1` = count × CIRCUNF_MM (32-bit; max 65535 × 2100 fits)
    - `numero2` = DIVISOR
    - next state ENTREGAR.
  - **ENTREGAR:** hold `numero1` / `numero2` stable. On the first cycle with `recibido1` && `recibido2`:
    - `validar` = 1 for that cycle only
    - load latency counter, go to ESPERAR.
  - **ESPERAR:** count LATENCIA cycles. On the last cycle, `listosNumeros` = 1 for one cycle, then go to CONTAR.
- **Overrun.** If fin_ventana occurs while in ENTREGAR or ESPERAR:
  - set `error_sobrecarga` (cleared only by reset);
  - discard that window's count (cleared as usual);
  - outputs and FSM are unaffected.
- **Zero pulses.** A window still delivers `numero1`=0 with the full handshake, so the accumulator adds 0.
- **Reset mid-handshake.** Strobes drop immediately; no partial delivery resumes.

Optional Feature:
- Macro MEDIDOR_PERIODO_EN.
- When defined:
  - adds output `periodo_ultimo` [31:0]: clock cycles between the two most recent pulses;
  - internal 32-bit counter, saturating at 0xFFFFFFFF;
  - on each pulse, `periodo_ultimo` takes the counter value and the counter restarts at 1;
  - `periodo_ultimo` resets to 0.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package `velocimetro_pkg`:
  - FSM state enum (CONTAR, ENTREGAR, ESPERAR);
  - width constants ANCHO_DATO=32, ANCHO_PULSOS=16;
  - default DIVISOR and CIRCUNF_MM constants.
- One sub-module `antirrebote`: synchroniser, debounce counter and rising-edge detect. Ports: clock, reset, entrada, nivel, flanco; parameter DEBOUNCE_CICLOS.

Test Plan:
All cases use VENTANA_CICLOS=1000, DEBOUNCE_CICLOS=4, LATENCIA=5, CIRCUNF_MM=2100, DIVISOR=1000.
- **Basic delivery.** 3 clean pulses (20 cycles high/low each) in window 1, `recibido1`=`recibido2`=1 → `numero1`=6300, `numero2`=1000, `pulsos_ventana`=3; `validar` once, one cycle after capture; `listosNumeros` 5 cycles later.
- **Bounce rejection.** Glitches of 1–3 cycles on `sensor` plus 1 clean pulse → `pulsos_ventana`=1, `numero1`=2100.
- **Ready stall.** `recibido2`=0 for 50 cycles after capture → `numero1` stable, `validar` stays 0; `validar` pulses on the first cycle both readies are 1.
- **Overrun.** Hold `recibido1`=0 through a whole window → `error_sobrecarga`=1 after the next fin_ventana; the first window still delivers once readies return; flag persists until reset.
- **Boundary and reset.** Filtered pulse edge on the fin_ventana cycle counts in the ending window. Assert `reset` during ESPERAR → all outputs 0 immediately, FSM returns to CONTAR, next window is delivered normally.
- **MEDIDOR_PERIODO_EN defined.** Pulses 150 cycles apart → `periodo_ultimo`=150 after the second pulse.

Source files
------------

// File: rtl/velocimetro_pkg.sv
// Shared types and constants for the velocimetro datapath front end.
package velocimetro_pkg;

    localparam int ANCHO_DATO     = 32;
    localparam int ANCHO_PULSOS   = 16;
    localparam int CIRCUNF_MM_DEF = 2100;
    localparam int DIVISOR_DEF    = 1000;

    typedef enum logic [1:0] {
        CONTAR   = 2'd0,
        ENTREGAR = 2'd1,
        ESPERAR  = 2'd2
    } estado_t;

    // Pulse count increment that sticks at all-ones instead of wrapping.
    function automatic logic [ANCHO_PULSOS-1:0] suma_sat(
        input logic [ANCHO_PULSOS-1:0] a,
        input logic                    b
    );
        if (b && (a == {ANCHO_PULSOS{1'b1}}))
            return a;
        return a + {{(ANCHO_PULSOS-1){1'b0}}, b};
    endfunction

endpackage

// File: rtl/medidor_pulsos_antirrebote.sv
// Two-flop synchroniser, debounce filter and rising-edge detect for the wheel sensor.
module antirrebote #(
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic nivel,
    output logic flanco
);

    localparam int ANCHO_CNT = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [ANCHO_CNT-1:0] CNT_FIN = ANCHO_CNT'(DEBOUNCE_CICLOS - 1);

    logic [1:0]           sync_reg;
    logic                 sinc;
    logic [ANCHO_CNT-1:0] cuenta_reg;
    logic [ANCHO_CNT-1:0] cuenta_next;
    logic                 nivel_reg;
    logic                 nivel_next;
    logic                 flanco_reg;
    logic                 flanco_next;

    assign sinc = sync_reg[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            sync_reg <= 2'b00;
        else
            sync_reg <= {sync_reg[0], entrada};
    end

    // The level only changes after DEBOUNCE_CICLOS consecutive differing samples;
    // any sample equal to the current level restarts the run.
    always_comb begin
        cuenta_next = '0;
        nivel_next  = nivel_reg;
        flanco_next = 1'b0;
        if (sinc != nivel_reg) begin
            if (cuenta_reg == CNT_FIN) begin
                nivel_next  = sinc;
                flanco_next = sinc;
            end else begin
                cuenta_next = cuenta_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cuenta_reg <= '0;
            nivel_reg  <= 1'b0;
            flanco_reg <= 1'b0;
        end else begin
            cuenta_reg <= cuenta_next;
            nivel_reg  <= nivel_next;
            flanco_reg <= flanco_next;
        end
    end

    assign nivel  = nivel_reg;
    assign flanco = flanco_reg;

endmodule

// File: rtl/medidor_pulsos.sv
// Wheel pulse counter per time window with handshake into the float stage.
// Optional MEDIDOR_PERIODO_EN adds periodo_ultimo (cycles between the last two pulses).
module medidor_pulsos
    import velocimetro_pkg::*;
#(
    parameter int VENTANA_CICLOS  = 50000000,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int CIRCUNF_MM      = CIRCUNF_MM_DEF,
    parameter int DIVISOR         = DIVISOR_DEF,
    parameter int LATENCIA        = 40
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sensor,
    input  logic                    recibido1,
    input  logic                    recibido2,
    output logic [ANCHO_DATO-1:0]   numero1,
    output logic [ANCHO_DATO-1:0]   numero2,
    output logic                    validar,
    output logic                    listosNumeros,
    output logic [ANCHO_PULSOS-1:0] pulsos_ventana,
    output logic                    error_sobrecarga
`ifdef MEDIDOR_PERIODO_EN
    ,
    output logic [ANCHO_DATO-1:0]   periodo_ultimo
`endif
);

    localparam int ANCHO_VENT = (VENTANA_CICLOS > 1) ? $clog2(VENTANA_CICLOS) : 1;
    localparam logic [ANCHO_VENT-1:0] VENT_FIN = ANCHO_VENT'(VENTANA_CICLOS - 1);
    localparam int ANCHO_LAT = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
    localparam logic [ANCHO_LAT-1:0] LAT_FIN = ANCHO_LAT'(LATENCIA - 1);
    localparam logic [ANCHO_DATO-1:0] CIRC_U = ANCHO_DATO'(CIRCUNF_MM);
    localparam logic [ANCHO_DATO-1:0] DIV_U  = ANCHO_DATO'(DIVISOR);

    logic nivel_filtrado;
    logic flanco_filtrado;
    logic pulso;

    antirrebote #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_antirrebote (
        .clock  (clock),
        .reset  (reset),
        .entrada(sensor),
        .nivel  (nivel_filtrado),
        .flanco (flanco_filtrado)
    );

    assign pulso = flanco_filtrado & nivel_filtrado;

    logic [ANCHO_VENT-1:0] ventana_reg;
    logic                  fin_ventana;

    assign fin_ventana = (ventana_reg == VENT_FIN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            ventana_reg <= '0;
        else if (fin_ventana)
            ventana_reg <= '0;
        else
            ventana_reg <= ventana_reg + 1'b1;
    end

    // conteo_total includes a pulse landing on the fin_ventana cycle, so that
    // pulse is captured with the ending window rather than the next one.
    logic [ANCHO_PULSOS-1:0] conteo_reg;
    logic [ANCHO_PULSOS-1:0] conteo_total;

    assign conteo_total = suma_sat(conteo_reg, pulso);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            conteo_reg <= '0;
        else if (fin_ventana)
            conteo_reg <= '0;
        else
            conteo_reg <= conteo_total;
    end

    estado_t               estado_reg;
    estado_t               estado_next;
    logic [ANCHO_LAT-1:0]  lat_reg;
    logic [ANCHO_LAT-1:0]  lat_next;
    logic                  captura;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_reg <= CONTAR;
            lat_reg    <= '0;
        end else begin
            estado_reg <= estado_next;
            lat_reg    <= lat_next;
        end
    end

    always_comb begin
        estado_next   = estado_reg;
        lat_next      = lat_reg;
        captura       = 1'b0;
        validar       = 1'b0;
        listosNumeros = 1'b0;
        case (estado_reg)
            CONTAR: begin
                if (fin_ventana) begin
                    captura     = 1'b1;
                    estado_next = ENTREGAR;
                end
            end
            ENTREGAR: begin
                if (recibido1 && recibido2) begin
                    validar     = 1'b1;
                    lat_next    = LAT_FIN;
                    estado_next = ESPERAR;
                end
            end
            ESPERAR: begin
                if (lat_reg == '0) begin
                    listosNumeros = 1'b1;
                    estado_next   = CONTAR;
                end else begin
                    lat_next = lat_reg - 1'b1;
                end
            end
            default: estado_next = CONTAR;
        endcase
    end

    logic [ANCHO_DATO-1:0]   numero1_reg;
    logic [ANCHO_DATO-1:0]   numero2_reg;
    logic [ANCHO_PULSOS-1:0] pulsos_reg;
    logic                    error_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            numero1_reg <= '0;
            numero2_reg <= '0;
            pulsos_reg  <= '0;
        end else if (captura) begin
            numero1_reg <= ANCHO_DATO'(conteo_total) * CIRC_U;
            numero2_reg <= DIV_U;
            pulsos_reg  <= conteo_total;
        end
    end

    // A window ending while a delivery is still in flight is dropped and flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            error_reg <= 1'b0;
        else if (fin_ventana && (estado_reg != CONTAR))
            error_reg <= 1'b1;
    end

    assign numero1          = numero1_reg;
    assign numero2          = numero2_reg;
    assign pulsos_ventana   = pulsos_reg;
    assign error_sobrecarga = error_reg;

`ifdef MEDIDOR_PERIODO_EN
    logic [ANCHO_DATO-1:0] periodo_cnt_reg;
    logic [ANCHO_DATO-1:0] periodo_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            periodo_cnt_reg <= '0;
            periodo_reg     <= '0;
        end else if (pulso) begin
            periodo_reg     <= periodo_cnt_reg;
            periodo_cnt_reg <= {{(ANCHO_DATO-1){1'b0}}, 1'b1};
        end else if (periodo_cnt_reg != {ANCHO_DATO{1'b1}}) begin
            periodo_cnt_reg <= periodo_cnt_reg + 1'b1;
        end
    end

    assign periodo_ultimo = periodo_reg;
`endif

endmodule

// File: tb/tb_medidor_pulsos.sv
// Directed bench for medidor_pulsos: table of windows plus hand-written corner sequences.
module tb_medidor_pulsos;

    localparam int V = 1000;
    localparam int D = 4;
    localparam int L = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sensor = 1'b0;
    logic        recibido1 = 1'b1;
    logic        recibido2 = 1'b1;
    logic [31:0] numero1;
    logic [31:0] numero2;
    logic        validar;
    logic        listosNumeros;
    logic [15:0] pulsos_ventana;
    logic        error_sobrecarga;
`ifdef MEDIDOR_PERIODO_EN
    logic [31:0] periodo_ultimo;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    medidor_pulsos #(
        .VENTANA_CICLOS (V),
        .DEBOUNCE_CICLOS(D),
        .CIRCUNF_MM     (2100),
        .DIVISOR        (1000),
        .LATENCIA       (L)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .sensor          (sensor),
        .recibido1       (recibido1),
        .recibido2       (recibido2),
        .numero1         (numero1),
        .numero2         (numero2),
        .validar         (validar),
        .listosNumeros   (listosNumeros),
        .pulsos_ventana  (pulsos_ventana),
        .error_sobrecarga(error_sobrecarga)
`ifdef MEDIDOR_PERIODO_EN
        ,
        .periodo_ultimo  (periodo_ultimo)
`endif
    );

    always #5 clock = ~clock;

    // cyc equals the DUT window position (mod V) when read at a negedge.
    always @(posedge clock) begin
        if (reset)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    typedef struct {
        int          n;
        bit          rebote;
        int          espera;
        logic [31:0] n1;
        logic [15:0] p;
    } vec_t;

    localparam int NV = 5;
    vec_t vec [NV];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
        n_cmp++;
        if (act !== esp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d (cyc=%0d)", nombre, act, esp, cyc);
        end
    endtask

    task automatic hasta(input int k);
        while (cyc < k) @(negedge clock);
    endtask

    task automatic pulsos(input int n, input bit rebote);
        if (rebote) begin
            for (int g = 1; g <= 3; g++) begin
                sensor = 1'b1;
                repeat (g) @(negedge clock);
                sensor = 1'b0;
                repeat (10) @(negedge clock);
            end
        end
        for (int p = 0; p < n; p++) begin
            sensor = 1'b1;
            repeat (20) @(negedge clock);
            sensor = 1'b0;
            repeat (20) @(negedge clock);
        end
    endtask

    // Raise both readies, expect validar now and listosNumeros exactly L cycles later.
    task automatic handshake();
        bit ok;
        recibido1 = 1'b1;
        recibido2 = 1'b1;
        #1;
        chk("validar", 32'(validar), 32'd1);
        ok = 1'b1;
        for (int i = 1; i < L; i++) begin
            @(negedge clock);
            #1;
            if (listosNumeros !== 1'b0 || validar !== 1'b0) ok = 1'b0;
        end
        chk("listos_previo", 32'(ok), 32'd1);
        @(negedge clock);
        #1;
        chk("listos", 32'(listosNumeros), 32'd1);
        @(negedge clock);
        #1;
        chk("listos_unico", 32'(listosNumeros), 32'd0);
    endtask

    task automatic entrega(input int w, input logic [31:0] n1, input logic [15:0] p,
                           input int espera, input logic err);
        bit ok;
        hasta(w);
        #1;
        chk("numero1", numero1, n1);
        chk("numero2", numero2, 32'd1000);
        chk("pulsos_ventana", 32'(pulsos_ventana), 32'(p));
        chk("error_sobrecarga", 32'(error_sobrecarga), 32'(err));
        if (espera > 0) begin
            ok = 1'b1;
            for (int i = 0; i < espera; i++) begin
                if (validar !== 1'b0 || numero1 !== n1) ok = 1'b0;
                @(negedge clock);
                #1;
            end
            chk("espera_estable", 32'(ok), 32'd1);
        end
        handshake();
        $display("entrega ventana_fin=%0d numero1=%0d numero2=%0d pulsos=%0d espera=%0d",
                 w, numero1, numero2, pulsos_ventana, espera);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vec[0] = '{n: 3, rebote: 1'b0, espera: 0,  n1: 32'd6300,  p: 16'd3};
        vec[1] = '{n: 1, rebote: 1'b1, espera: 0,  n1: 32'd2100,  p: 16'd1};
        vec[2] = '{n: 0, rebote: 1'b0, espera: 0,  n1: 32'd0,     p: 16'd0};
        vec[3] = '{n: 5, rebote: 1'b0, espera: 50, n1: 32'd10500, p: 16'd5};
        vec[4] = '{n: 2, rebote: 1'b1, espera: 0,  n1: 32'd4200,  p: 16'd2};

        repeat (3) @(negedge clock);
        chk("rst_numero1", numero1, 32'd0);
        chk("rst_numero2", numero2, 32'd0);
        chk("rst_pulsos", 32'(pulsos_ventana), 32'd0);
        chk("rst_validar", 32'(validar), 32'd0);
        chk("rst_listos", 32'(listosNumeros), 32'd0);
        chk("rst_error", 32'(error_sobrecarga), 32'd0);
        $display("reset comprobado");
        reset = 1'b0;

        // Window i carries vec[i]; its delivery is checked at the start of window i+1.
        for (int i = 0; i < NV; i++) begin
            if (i > 0)
                entrega(i * V, vec[i-1].n1, vec[i-1].p, vec[i-1].espera, 1'b0);
            hasta(i * V + 100);
            pulsos(vec[i].n, vec[i].rebote);
            if (vec[i].espera > 0) begin
                hasta(i * V + 990);
                recibido2 = 1'b0;
            end
        end
        entrega(NV * V, vec[NV-1].n1, vec[NV-1].p, vec[NV-1].espera, 1'b0);

        // Filtered edge lands on the fin_ventana cycle 5999 (2 + D cycles after 5993).
        hasta(5993);
        sensor = 1'b1;
        entrega(6000, 32'd2100, 16'd1, 0, 1'b0);
        hasta(6100);
        sensor = 1'b0;
        entrega(7000, 32'd0, 16'd0, 0, 1'b0);

        // Overrun: delivery of window 7000 stalled through all of window 8000.
        hasta(7100);
        pulsos(2, 1'b0);
        hasta(7990);
        recibido1 = 1'b0;
        hasta(8000);
        #1;
        chk("sobre_validar_bloq", 32'(validar), 32'd0);
        chk("sobre_numero1", numero1, 32'd4200);
        hasta(8100);
        pulsos(1, 1'b0);
        hasta(8999);
        #1;
        chk("sobre_error_antes", 32'(error_sobrecarga), 32'd0);
        hasta(9000);
        #1;
        chk("sobre_error", 32'(error_sobrecarga), 32'd1);
        chk("sobre_numero1_ret", numero1, 32'd4200);
        chk("sobre_pulsos_ret", 32'(pulsos_ventana), 32'd2);
        chk("sobre_validar_0", 32'(validar), 32'd0);
        handshake();
        $display("entrega tras sobrecarga numero1=%0d error=%0d", numero1, error_sobrecarga);
        entrega(10000, 32'd0, 16'd0, 0, 1'b1);

        // Reset asserted while waiting for listosNumeros.
        hasta(10100);
        pulsos(1, 1'b0);
        hasta(11000);
        #1;
        chk("pre_rst_validar", 32'(validar), 32'd1);
        hasta(11002);
        reset = 1'b1;
        #1;
        chk("mid_rst_numero1", numero1, 32'd0);
        chk("mid_rst_numero2", numero2, 32'd0);
        chk("mid_rst_pulsos", 32'(pulsos_ventana), 32'd0);
        chk("mid_rst_strobes", {30'd0, validar, listosNumeros}, 32'd0);
        chk("mid_rst_error", 32'(error_sobrecarga), 32'd0);
        $display("reset en ESPERAR comprobado");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            if (listosNumeros !== 1'b0 || validar !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_sin_strobes", 32'(ok), 32'd1);
        hasta(100);
        pulsos(2, 1'b0);
        entrega(1000, 32'd4200, 16'd2, 0, 1'b0);

`ifdef MEDIDOR_PERIODO_EN
        // Rising edges 150 cycles apart.
        hasta(1100);
        sensor = 1'b1;
        hasta(1120);
        sensor = 1'b0;
        hasta(1250);
        sensor = 1'b1;
        hasta(1270);
        sensor = 1'b0;
        hasta(1300);
        #1;
        chk("periodo_ultimo", periodo_ultimo, 32'd150);
        $display("periodo_ultimo=%0d", periodo_ultimo);
        entrega(2000, 32'd4200, 16'd2, 0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
